hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the IF/ID and ID/EX pipeline registers of the MIPS core. It detects load-use hazards, taken-branch flushes and memory-busy freezes. From these it drives the PC write enable, the IF/ID write enable and the flush (bubble-insert) controls of both stage registers. It sits in the ID stage beside the control unit and drives the enables and clears of the stage registers.

---
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline hazard controller for the ID stage of the MIPS core. It drives the
// PC write enable, the IF/ID load enable and the bubble-insert clears of the
// IF/ID and ID/EX stage registers. It handles three conditions:
//   - load-use hazards: a one-cycle stall that inserts a bubble into EX
//   - taken-branch flushes: BR_FLUSH_CYCLES cycles of flush
//   - memory-busy freezes: the whole front end holds its state
//
// There is no valid/ready handshake. Every output is a level that is valid in
// the cycle it is produced. All outputs are combinational from the FSM state
// and the current inputs.
//
// Ports
//   clk              in   pipeline clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   id_rs, id_rt     in   source specifiers of the instruction in ID
//   id_uses_rt       in   ID instruction reads rt as a source
//   ex_rt            in   rt (load destination) of the instruction in EX
//   ex_memtoreg      in   EX instruction is a load
//   ex_branch_taken  in   branch resolved taken in EX
//   mem_busy         in   data memory not ready; freeze the pipeline
//   pc_write         out  PC update enable
//   ifid_write       out  IF/ID load enable
//   ifid_flush       out  IF/ID clear to NOP
//   idex_flush       out  ID/EX control-field clear
//   state            out  FSM state (RUN=0, FLUSH=1, WAIT=2), exposed for debug
//   stall_cnt        out  saturating count of load-use stall cycles
//   flush_cnt        out  saturating count of cycles with idex_flush asserted
//
// Configuration
//   HAZARD_STATS_EN  when defined, the statistics counters are built. When it
//                    is undefined, stall_cnt and flush_cnt are tied to 0.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_W           = 5,
    parameter int BR_FLUSH_CYCLES = 2,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // The branch cycle itself is the first flush cycle. FLUSH therefore only
    // covers the remaining BR_FLUSH_CYCLES-1 cycles.
    localparam logic [3:0] BR_LOAD = 4'(BR_FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    logic [3:0] fcnt_q, fcnt_d;

    logic lu;
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c;

    // A load into r0 never creates a hazard, because r0 is hard-wired to zero.
    assign lu = ex_memtoreg & (ex_rt != '0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        fcnt_d       = fcnt_q;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    ret_d        = RUN;
                    state_d      = WAIT;
                end else if (ex_branch_taken) begin
                    // The flush wins over a simultaneous load-use stall.
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    fcnt_d       = BR_LOAD;
                    if (BR_LOAD != 4'd0) begin
                        state_d = FLUSH;
                    end
                end else if (lu) begin
                    // Hold PC and IF/ID, and send a bubble into EX. Next cycle
                    // the bubble sits in EX, so lu clears by itself.
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    ret_d        = FLUSH;
                    state_d      = WAIT;
                end else begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    fcnt_d       = fcnt_q - 4'd1;
                    if (fcnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
            end
            WAIT: begin
                // The exit cycle is frozen as well. Normal flow resumes one
                // cycle after mem_busy drops.
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                if (!mem_busy) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // While rst_n is low, both stage registers are held cleared and the PC is
    // held.
    assign pc_write   = rst_n & pc_write_c;
    assign ifid_write = rst_n & ifid_write_c;
    assign ifid_flush = ~rst_n | ifid_flush_c;
    assign idex_flush = ~rst_n | idex_flush_c;
    assign state      = rst_n ? state_q : RUN;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_ev;

    // A stall only counts when lu actually takes effect: RUN, with no freeze
    // and no branch overriding it.
    assign stall_ev = (state_q == RUN) & ~mem_busy & ~ex_branch_taken & lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ev && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (idex_flush_c && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. The driver applies one directed vector per cycle,
// shortly after the rising edge. It pushes the hand-computed expected outputs
// onto exp_q. A monitor samples the DUT on each falling edge and pops and
// compares whenever an expectation is pending.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int EXP_W = 6 + 2 * CNT_W;

  // Expected control nibbles: {pc_write, ifid_write, ifid_flush, idex_flush}
  localparam logic [3:0] C_NORM  = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_FRZ   = 4'b0000;
  localparam logic [3:0] C_RST   = 4'b0011;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_memtoreg = 1'b0;
  logic             ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_W(REG_W), .BR_FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rt           (ex_rt),
    .ex_memtoreg     (ex_memtoreg),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .state           (state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // driver
  task automatic step(input logic rst, input logic [REG_W-1:0] rs,
                      input logic [REG_W-1:0] rt, input logic uses_rt,
                      input logic [REG_W-1:0] ert, input logic m2r,
                      input logic br, input logic busy,
                      input logic [3:0] ctrl, input logic [1:0] st);
    logic [CNT_W-1:0] es, ef;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
    ex_rt = ert; ex_memtoreg = m2r; ex_branch_taken = br; mem_busy = busy;
    if (!rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end
`ifdef HAZARD_STATS_EN
    es = CNT_W'(exp_stall);
    ef = CNT_W'(exp_flush);
`else
    es = '0;
    ef = '0;
`endif
    exp_q.push_back({ctrl, st, es, ef});
    // Counters are registered, so this cycle's events show up next cycle.
    if (rst && ctrl == C_STALL) exp_stall++;
    if (rst && ctrl[0]) exp_flush++;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [3:0] act_ctrl, exp_ctrl;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_ctrl = e[EXP_W-1 -: 4];
      act_ctrl = {pc_write, ifid_write, ifid_flush, idex_flush};
      checks++;
      if (act_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL ctrl t=%0t got %b expected %b", $time, act_ctrl, exp_ctrl);
      end
      checks++;
      if (state !== e[2*CNT_W +: 2]) begin
        errors++;
        $display("FAIL state t=%0t got %0d expected %0d", $time, state, e[2*CNT_W +: 2]);
      end
      checks++;
      if (stall_cnt !== e[CNT_W +: CNT_W]) begin
        errors++;
        $display("FAIL stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, e[CNT_W +: CNT_W]);
      end
      checks++;
      if (flush_cnt !== e[CNT_W-1:0]) begin
        errors++;
        $display("FAIL flush_cnt t=%0t got %0d expected %0d", $time, flush_cnt, e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    // reset held for three cycles
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);
    // load-use via rs, then clear
    step(1, 5, 0, 0, 5, 1, 0, 0, C_STALL, 2'd0);
    step(1, 5, 0, 0, 5, 0, 0, 0, C_NORM, 2'd0);
    // ex_rt == 0 is never a hazard
    step(1, 0, 0, 1, 0, 1, 0, 0, C_NORM, 2'd0);
    // rt match with and without id_uses_rt
    step(1, 3, 7, 1, 7, 1, 0, 0, C_STALL, 2'd0);
    step(1, 3, 7, 0, 7, 1, 0, 0, C_NORM, 2'd0);
    // rs == rt == ex_rt: a single stall
    step(1, 9, 9, 1, 9, 1, 0, 0, C_STALL, 2'd0);
    step(1, 9, 9, 1, 9, 0, 0, 0, C_NORM, 2'd0);
    // branch with a simultaneous load-use: flush wins, two flush cycles
    step(1, 4, 0, 0, 4, 1, 1, 0, C_FLUSH, 2'd0);
    step(1, 4, 0, 0, 4, 1, 0, 0, C_FLUSH, 2'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);
    // memory freeze for four cycles, plus the exit cycle
    step(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);
    // freeze beats branch; the branch is seen again after WAIT
    step(1, 0, 0, 0, 0, 0, 1, 1, C_FRZ, 2'd0);
    step(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2'd2);
    step(1, 0, 0, 0, 0, 0, 1, 0, C_FLUSH, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, 2'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);
    // freeze in the middle of a flush
    step(1, 0, 0, 0, 0, 0, 1, 0, C_FLUSH, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd1);
    step(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, 2'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);
    // asynchronous reset dropped between edges while in WAIT
    step(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 1, C_RST, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);
    step(1, 6, 0, 0, 6, 1, 0, 0, C_STALL, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'd0);

    // drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
